// File: rtl/l1i_cache.sv
// Direct-mapped L1 instruction cache: registered one-cycle lookup returning up to four instructions,
// blocking miss handling and a separate preload port. Define L1I_PID_MATCH_EN to require PID/TID match on hit.
module l1i_cache #(
    parameter int fetchingAddressWidth    = 64,
    parameter int cacheLineWith           = 512,
    parameter int instructionWidth        = 32,
    parameter int offsetWidth             = 6,
    parameter int indexWidth              = 8,
    parameter int tagWidth                = fetchingAddressWidth - indexWidth - offsetWidth,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64
) (
    input  logic                               clock_i,
    input  logic                               cacheReset_i,
    input  logic                               fetchEnable_i,
    input  logic                               fetchStall_i,
    input  logic [PidSize-1:0]                 Pid_i,
    input  logic [TidSize-1:0]                 Tid_i,
    input  logic [fetchingAddressWidth-1:0]    fetchAddress_i,
    input  logic                               cacheUpdate_i,
    input  logic [fetchingAddressWidth-1:0]    cacheUpdateAddress_i,
    input  logic [PidSize-1:0]                 cacheUpdatePid_i,
    input  logic [TidSize-1:0]                 cacheUpdateTid_i,
    input  logic [cacheLineWith-1:0]           cacheUpdateLine1_i,
    input  logic                               naturalWriteEn_i,
    input  logic [fetchingAddressWidth-1:0]    naturalWriteAddress_i,
    input  logic [cacheLineWith-1:0]           naturalWriteLine_i,
    input  logic [PidSize-1:0]                 naturalPid_i,
    input  logic [TidSize-1:0]                 naturalTid_i,
    output logic                               outputEnable_o,
    output logic [4*instructionWidth-1:0]      outputBundle_o,
    output logic [fetchingAddressWidth-1:0]    bundleAddress_o,
    output logic [1:0]                         bundleLen_o,
    output logic [PidSize-1:0]                 bundlePid_o,
    output logic [TidSize-1:0]                 bundleTid_o,
    output logic [instructionCounterWidth-1:0] bundleStartMajId_o,
    output logic                               cacheMiss_o,
    output logic [fetchingAddressWidth-1:0]    missedAddress_o,
    output logic [instructionCounterWidth-1:0] missedInstMajorId_o,
    output logic [PidSize-1:0]                 missedPid_o,
    output logic [TidSize-1:0]                 missedTid_o
);
    localparam int BundleSize = 4 * instructionWidth;
    localparam int NumLines   = 1 << indexWidth;
    localparam int ByteSelW   = $clog2(instructionWidth / 8);
    localparam int SlotW      = offsetWidth - ByteSelW;
    localparam int InstShiftW = $clog2(instructionWidth);

    logic [NumLines-1:0]      valid_q;
    logic [tagWidth-1:0]      tag_mem  [NumLines];
    logic [PidSize-1:0]       pid_mem  [NumLines];
    logic [TidSize-1:0]       tid_mem  [NumLines];
    logic [cacheLineWith-1:0] data_mem [NumLines];

    logic                            wr_en;
    logic [fetchingAddressWidth-1:0] wr_addr;
    logic [PidSize-1:0]              wr_pid;
    logic [TidSize-1:0]              wr_tid;
    logic [cacheLineWith-1:0]        wr_line;
    logic [indexWidth-1:0]           wr_index;
    logic [tagWidth-1:0]             wr_tag;

    // Refill wins over preload when both target the array in the same cycle
    assign wr_en = cacheUpdate_i | naturalWriteEn_i;
    always_comb begin
        if (cacheUpdate_i) begin
            wr_addr = cacheUpdateAddress_i;
            wr_pid  = cacheUpdatePid_i;
            wr_tid  = cacheUpdateTid_i;
            wr_line = cacheUpdateLine1_i;
        end else begin
            wr_addr = naturalWriteAddress_i;
            wr_pid  = naturalPid_i;
            wr_tid  = naturalTid_i;
            wr_line = naturalWriteLine_i;
        end
    end
    assign wr_index = wr_addr[offsetWidth +: indexWidth];
    assign wr_tag   = wr_addr[fetchingAddressWidth-1 -: tagWidth];

    logic [indexWidth-1:0]              f_index;
    logic [tagWidth-1:0]                f_tag;
    logic [SlotW-1:0]                   f_slot;
    logic [SlotW-1:0]                   slots_after;
    logic [SlotW+InstShiftW-1:0]        shift_amt;
    logic [cacheLineWith-1:0]           shifted_line;
    logic [BundleSize-1:0]              bundle_data;
    logic [1:0]                         bundle_len;
    logic [2:0]                         inst_count;
    logic                               tag_hit;
    logic                               hit;

    assign f_index = fetchAddress_i[offsetWidth +: indexWidth];
    assign f_tag   = fetchAddress_i[fetchingAddressWidth-1 -: tagWidth];
    assign f_slot  = fetchAddress_i[ByteSelW +: SlotW];
    assign tag_hit = valid_q[f_index] && (tag_mem[f_index] == f_tag);

`ifdef L1I_PID_MATCH_EN
    assign hit = tag_hit && (pid_mem[f_index] == Pid_i) && (tid_mem[f_index] == Tid_i);
`else
    logic unused_owner;
    assign unused_owner = ^{pid_mem[f_index], tid_mem[f_index]};
    assign hit = tag_hit;
`endif

    logic unused_wr_offset;
    assign unused_wr_offset = ^wr_addr[offsetWidth-1:0];

    // Instruction 0 sits at the line MSB; shifting left by the slot left-justifies and zero-fills the tail
    assign shift_amt    = {f_slot, {InstShiftW{1'b0}}};
    assign shifted_line = data_mem[f_index] << shift_amt;
    assign bundle_data  = shifted_line[cacheLineWith-1 -: BundleSize];
    assign slots_after  = ~f_slot;
    assign bundle_len   = (|slots_after[SlotW-1:2]) ? 2'd3 : slots_after[1:0];
    assign inst_count   = {1'b0, bundle_len} + 3'd1;

    logic                               outputEnable_q, outputEnable_d;
    logic [BundleSize-1:0]              outputBundle_q, outputBundle_d;
    logic [fetchingAddressWidth-1:0]    bundleAddress_q, bundleAddress_d;
    logic [1:0]                         bundleLen_q, bundleLen_d;
    logic [PidSize-1:0]                 bundlePid_q, bundlePid_d;
    logic [TidSize-1:0]                 bundleTid_q, bundleTid_d;
    logic [instructionCounterWidth-1:0] bundleMaj_q, bundleMaj_d;
    logic                               cacheMiss_q, cacheMiss_d;
    logic [fetchingAddressWidth-1:0]    missedAddress_q, missedAddress_d;
    logic [instructionCounterWidth-1:0] missedMaj_q, missedMaj_d;
    logic [PidSize-1:0]                 missedPid_q, missedPid_d;
    logic [TidSize-1:0]                 missedTid_q, missedTid_d;
    logic [instructionCounterWidth-1:0] majId_q, majId_d;
    logic                               missPending_q, missPending_d;

    always_comb begin
        outputEnable_d  = outputEnable_q;
        outputBundle_d  = outputBundle_q;
        bundleAddress_d = bundleAddress_q;
        bundleLen_d     = bundleLen_q;
        bundlePid_d     = bundlePid_q;
        bundleTid_d     = bundleTid_q;
        bundleMaj_d     = bundleMaj_q;
        cacheMiss_d     = cacheMiss_q;
        missedAddress_d = missedAddress_q;
        missedMaj_d     = missedMaj_q;
        missedPid_d     = missedPid_q;
        missedTid_d     = missedTid_q;
        majId_d         = majId_q;
        missPending_d   = missPending_q;
        if (cacheUpdate_i) begin
            missPending_d = 1'b0;
        end
        // A stall freezes every output and the ID counter; writes above still proceed
        if (!fetchStall_i) begin
            if (fetchEnable_i && !missPending_q) begin
                if (hit) begin
                    outputEnable_d  = 1'b1;
                    cacheMiss_d     = 1'b0;
                    outputBundle_d  = bundle_data;
                    bundleAddress_d = fetchAddress_i;
                    bundleLen_d     = bundle_len;
                    bundlePid_d     = Pid_i;
                    bundleTid_d     = Tid_i;
                    bundleMaj_d     = majId_q;
                    majId_d         = majId_q + {{(instructionCounterWidth-3){1'b0}}, inst_count};
                end else begin
                    outputEnable_d  = 1'b0;
                    cacheMiss_d     = 1'b1;
                    missedAddress_d = fetchAddress_i;
                    missedMaj_d     = majId_q;
                    missedPid_d     = Pid_i;
                    missedTid_d     = Tid_i;
                    missPending_d   = 1'b1;
                end
            end else begin
                outputEnable_d = 1'b0;
                cacheMiss_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!cacheReset_i) begin
            valid_q         <= '0;
            outputEnable_q  <= 1'b0;
            outputBundle_q  <= '0;
            bundleAddress_q <= '0;
            bundleLen_q     <= '0;
            bundlePid_q     <= '0;
            bundleTid_q     <= '0;
            bundleMaj_q     <= '0;
            cacheMiss_q     <= 1'b0;
            missedAddress_q <= '0;
            missedMaj_q     <= '0;
            missedPid_q     <= '0;
            missedTid_q     <= '0;
            majId_q         <= '0;
            missPending_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                valid_q[wr_index] <= 1'b1;
            end
            outputEnable_q  <= outputEnable_d;
            outputBundle_q  <= outputBundle_d;
            bundleAddress_q <= bundleAddress_d;
            bundleLen_q     <= bundleLen_d;
            bundlePid_q     <= bundlePid_d;
            bundleTid_q     <= bundleTid_d;
            bundleMaj_q     <= bundleMaj_d;
            cacheMiss_q     <= cacheMiss_d;
            missedAddress_q <= missedAddress_d;
            missedMaj_q     <= missedMaj_d;
            missedPid_q     <= missedPid_d;
            missedTid_q     <= missedTid_d;
            majId_q         <= majId_d;
            missPending_q   <= missPending_d;
        end
    end

    // Line payload carries no reset; the valid bits alone decide whether it is meaningful
    always_ff @(posedge clock_i) begin
        if (cacheReset_i && wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            pid_mem[wr_index]  <= wr_pid;
            tid_mem[wr_index]  <= wr_tid;
            data_mem[wr_index] <= wr_line;
        end
    end

    assign outputEnable_o      = outputEnable_q;
    assign outputBundle_o      = outputBundle_q;
    assign bundleAddress_o     = bundleAddress_q;
    assign bundleLen_o         = bundleLen_q;
    assign bundlePid_o         = bundlePid_q;
    assign bundleTid_o         = bundleTid_q;
    assign bundleStartMajId_o  = bundleMaj_q;
    assign cacheMiss_o         = cacheMiss_q;
    assign missedAddress_o     = missedAddress_q;
    assign missedInstMajorId_o = missedMaj_q;
    assign missedPid_o         = missedPid_q;
    assign missedTid_o         = missedTid_q;
endmodule

// File: tb/tb_l1i_cache.sv
// Directed plus randomized bench for l1i_cache, checked against a word-level reference model.
`timescale 1ns/1ps
module tb_l1i_cache;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, fen, stall, upd, nat;
    logic [19:0]  pid, upd_pid, nat_pid;
    logic [15:0]  tid, upd_tid, nat_tid;
    logic [63:0]  faddr, upd_addr, nat_addr;
    logic [511:0] upd_line, nat_line;

    logic         outputEnable_o, cacheMiss_o;
    logic [127:0] outputBundle_o;
    logic [63:0]  bundleAddress_o, bundleStartMajId_o, missedAddress_o, missedInstMajorId_o;
    logic [1:0]   bundleLen_o;
    logic [19:0]  bundlePid_o, missedPid_o;
    logic [15:0]  bundleTid_o, missedTid_o;

    l1i_cache dut (
        .clock_i(clk), .cacheReset_i(rst_n), .fetchEnable_i(fen), .fetchStall_i(stall),
        .Pid_i(pid), .Tid_i(tid), .fetchAddress_i(faddr),
        .cacheUpdate_i(upd), .cacheUpdateAddress_i(upd_addr), .cacheUpdatePid_i(upd_pid),
        .cacheUpdateTid_i(upd_tid), .cacheUpdateLine1_i(upd_line),
        .naturalWriteEn_i(nat), .naturalWriteAddress_i(nat_addr), .naturalWriteLine_i(nat_line),
        .naturalPid_i(nat_pid), .naturalTid_i(nat_tid),
        .outputEnable_o(outputEnable_o), .outputBundle_o(outputBundle_o),
        .bundleAddress_o(bundleAddress_o), .bundleLen_o(bundleLen_o),
        .bundlePid_o(bundlePid_o), .bundleTid_o(bundleTid_o),
        .bundleStartMajId_o(bundleStartMajId_o), .cacheMiss_o(cacheMiss_o),
        .missedAddress_o(missedAddress_o), .missedInstMajorId_o(missedInstMajorId_o),
        .missedPid_o(missedPid_o), .missedTid_o(missedTid_o)
    );

    // Reference model: per-line word arrays, plus the expected registered outputs
    bit          m_valid [256];
    logic [49:0] m_tag   [256];
    logic [19:0] m_pid   [256];
    logic [15:0] m_tid   [256];
    logic [31:0] m_word  [256][16];
    bit          m_pend;
    logic [63:0] m_cnt;

    logic         exp_oe, exp_miss;
    logic [127:0] exp_bundle;
    logic [63:0]  exp_baddr, exp_maj, exp_maddr, exp_mmaj;
    logic [1:0]   exp_len;
    logic [19:0]  exp_bpid, exp_mpid;
    logic [15:0]  exp_btid, exp_mtid;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_write(input logic [63:0] a, input logic [19:0] p, input logic [15:0] t,
                               input logic [511:0] line);
        int idx;
        idx = int'((a / 64) % 256);
        m_valid[idx] = 1'b1;
        m_tag[idx]   = 50'(a / 16384);
        m_pid[idx]   = p;
        m_tid[idx]   = t;
        for (int k = 0; k < 16; k++) m_word[idx][k] = line[511-32*k -: 32];
    endtask

    task automatic model_edge();
        int idx, w, n;
        logic [49:0] tg;
        bit hit, new_pend;
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
            exp_oe = 0; exp_miss = 0; exp_bundle = '0; exp_baddr = '0; exp_maj = '0;
            exp_maddr = '0; exp_mmaj = '0; exp_len = '0; exp_bpid = '0; exp_mpid = '0;
            exp_btid = '0; exp_mtid = '0; m_cnt = '0; m_pend = 0;
            return;
        end
        new_pend = m_pend;
        if (upd) new_pend = 0;
        if (!stall) begin
            if (fen && !m_pend) begin
                idx = int'((faddr / 64) % 256);
                tg  = 50'(faddr / 16384);
                w   = int'((faddr / 4) % 16);
                hit = m_valid[idx] && (m_tag[idx] == tg);
`ifdef L1I_PID_MATCH_EN
                hit = hit && (m_pid[idx] == pid) && (m_tid[idx] == tid);
`endif
                if (hit) begin
                    n = (16 - w < 4) ? 16 - w : 4;
                    exp_bundle = '0;
                    for (int i = 0; i < n; i++) exp_bundle[127-32*i -: 32] = m_word[idx][w+i];
                    exp_oe = 1; exp_miss = 0; exp_len = 2'(n - 1); exp_baddr = faddr;
                    exp_bpid = pid; exp_btid = tid; exp_maj = m_cnt;
                    m_cnt = m_cnt + 64'(n);
                end else begin
                    exp_oe = 0; exp_miss = 1; exp_maddr = faddr; exp_mmaj = m_cnt;
                    exp_mpid = pid; exp_mtid = tid; new_pend = 1;
                end
            end else begin
                exp_oe = 0; exp_miss = 0;
            end
        end
        if (upd) model_write(upd_addr, upd_pid, upd_tid, upd_line);
        else if (nat) model_write(nat_addr, nat_pid, nat_tid, nat_line);
        m_pend = new_pend;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check("outputEnable", 128'(outputEnable_o), 128'(exp_oe));
        check("outputBundle", outputBundle_o, exp_bundle);
        check("bundleAddress", 128'(bundleAddress_o), 128'(exp_baddr));
        check("bundleLen", 128'(bundleLen_o), 128'(exp_len));
        check("bundlePid", 128'(bundlePid_o), 128'(exp_bpid));
        check("bundleTid", 128'(bundleTid_o), 128'(exp_btid));
        check("bundleStartMajId", 128'(bundleStartMajId_o), 128'(exp_maj));
        check("cacheMiss", 128'(cacheMiss_o), 128'(exp_miss));
        check("missedAddress", 128'(missedAddress_o), 128'(exp_maddr));
        check("missedMajId", 128'(missedInstMajorId_o), 128'(exp_mmaj));
        check("missedPid", 128'(missedPid_o), 128'(exp_mpid));
        check("missedTid", 128'(missedTid_o), 128'(exp_mtid));
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[511-32*k -: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [63:0] rand_addr();
        logic [49:0] tg;
        tg = ($urandom_range(0, 1) == 0) ? 50'h0 : 50'h3_FFFF_0000_0001;
        return {tg, 8'($urandom_range(0, 7)), 6'($urandom_range(0, 63))};
    endfunction

    task automatic idle();
        fen = 0; stall = 0; upd = 0; nat = 0;
    endtask

    task automatic fetch(input logic [63:0] a);
        idle();
        fen = 1; faddr = a;
        cycle();
    endtask

    logic [511:0] pattern_line, refill_line;

    initial begin
        rst_n = 0; pid = 20'h12345; tid = 16'hBEEF; faddr = '0;
        upd_addr = '0; upd_pid = 20'h0AAAA; upd_tid = 16'h1111; upd_line = '0;
        nat_addr = '0; nat_pid = 20'h0BBBB; nat_tid = 16'h2222; nat_line = '0;
        idle();
        // Reset must win over a concurrent fetch and write
        fen = 1; nat = 1; nat_line = rand_line();
        cycle();
        idle();
        cycle();
        rst_n = 1;
        fetch(64'h0);
        check("tp_first_miss", 128'(cacheMiss_o), 128'(1));
        check("tp_first_missaddr", 128'(missedAddress_o), 128'(0));

        idle(); upd = 1; upd_addr = 64'h0; upd_line = rand_line();
        cycle();

        pattern_line = rand_line();
        pattern_line[511:384] = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
        for (int l = 0; l < 10; l++) begin
            idle(); nat = 1; nat_addr = 64'(l * 64);
            nat_line = (l == 0) ? pattern_line : rand_line();
            cycle();
        end
        for (int a = 0; a <= 'h270; a += 16) begin
            fetch(64'(a));
            if (a == 0) check("tp_first_bundle", outputBundle_o, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
        end

        fetch(64'h280);
        check("tp_miss_280", 128'(missedAddress_o), 128'(64'h280));
        for (int a = 'h290; a <= 'h2B0; a += 16) fetch(64'(a));
        idle(); upd = 1; upd_addr = 64'h280; upd_line = rand_line();
        cycle();
        fetch(64'h280);
        check("tp_refill_hit", 128'(outputEnable_o), 128'(1));

        fetch(64'h38);
        check("tp_slot14_len", 128'(bundleLen_o), 128'(1));

        idle(); fen = 1; stall = 1; faddr = 64'h100;
        repeat (3) cycle();

        refill_line = rand_line();
        idle(); upd = 1; upd_addr = 64'h400; upd_line = refill_line;
        nat = 1; nat_addr = 64'h400; nat_line = rand_line();
        cycle();
        fetch(64'h400);
        check("tp_update_priority", outputBundle_o, refill_line[511:384]);

        // Lookup sees the old line while the same index is overwritten with a new tag
        idle(); fen = 1; faddr = 64'h0; nat = 1; nat_addr = 64'h4000; nat_line = rand_line();
        cycle();
        check("tp_read_before_write", outputBundle_o, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
        fetch(64'h0);
        idle(); upd = 1; upd_addr = 64'h0; upd_line = rand_line();
        cycle();

        for (int c = 0; c < 600; c++) begin
            idle();
            rst_n = ($urandom_range(0, 199) != 0);
            stall = ($urandom_range(0, 7) == 0);
            fen   = ($urandom_range(0, 3) != 0);
            faddr = rand_addr();
            pid   = ($urandom_range(0, 3) == 0) ? 20'h0BBBB : 20'h12345;
            tid   = ($urandom_range(0, 3) == 0) ? 16'h2222 : 16'hBEEF;
            nat   = ($urandom_range(0, 2) == 0);
            nat_addr = rand_addr(); nat_line = rand_line();
            nat_pid  = ($urandom_range(0, 1) == 0) ? 20'h0BBBB : 20'h12345;
            nat_tid  = ($urandom_range(0, 1) == 0) ? 16'h2222 : 16'hBEEF;
            if (m_pend && $urandom_range(0, 2) == 0) begin
                upd = 1; upd_addr = exp_maddr; upd_line = rand_line();
                upd_pid = exp_mpid; upd_tid = exp_mtid;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/l1i_cache.md
Name: l1i_cache

Overview:
Direct-mapped L1 instruction cache for the PowerPC fetch stage. Accepts a fetch address per cycle and returns a bundle of up to four 32-bit instructions one cycle later, tagged with PID/TID and a running major instruction ID. On a miss it reports the missed address upstream and blocks further fetches until the refill (cacheUpdate) arrives. A separate "natural write" port preloads lines outside miss handling.

Parameters:
fetchingAddressWidth, 64, fetch/update address width
cacheLineWith, 512, line width in bits (64 bytes, 16 instructions)
instructionWidth, 32, instruction width
offsetWidth, 6, byte offset within line
indexWidth, 8, index bits (256 lines)
tagWidth, fetchingAddressWidth-indexWidth-offsetWidth (50), tag bits
PidSize, 20, process ID width
TidSize, 16, thread ID width
instructionCounterWidth, 64, major instruction ID width
Local: bundleSize = 4*instructionWidth (128).

Ports:
clock_i  in  1  clock, all logic on rising edge
cacheReset_i  in  1  synchronous active-low reset
fetchEnable_i  in  1  fetch request valid
fetchStall_i  in  1  downstream stall; hold outputs
Pid_i / Tid_i  in  20/16  fetch PID/TID
fetchAddress_i  in  64  fetch byte address
cacheUpdate_i  in  1  miss refill write enable
cacheUpdateAddress_i  in  64  refill address
cacheUpdatePid_i / cacheUpdateTid_i  in  20/16  refill owner
cacheUpdateLine1_i  in  512  refill line data
naturalWriteEn_i  in  1  preload write enable
naturalWriteAddress_i  in  64  preload address
naturalWriteLine_i  in  512  preload line data
naturalPid_i / naturalTid_i  in  20/16  preload owner
outputEnable_o  out  1  bundle valid
outputBundle_o  out  128  instructions, first at bits [0:31]
bundleAddress_o  out  64  address of first instruction
bundleLen_o  out  2  instruction count minus 1
bundlePid_o / bundleTid_o  out  20/16  owner of bundle
bundleStartMajId_o  out  64  major ID of first instruction
cacheMiss_o  out  1  miss pulse
missedAddress_o  out  64  missed fetch address
missedInstMajorId_o  out  64  major ID at miss
missedPid_o / missedTid_o  out  20/16  missed owner

Behaviour:
- Big-endian bit numbering: tag=addr[0:49], index=addr[50:57], offset=addr[58:63]; instruction slot w=addr[58:61]; line instruction k occupies line bits [32k:32k+31].
- Storage: 256 entries of {valid, tag, PID, TID, 512-bit data}.
- Reset (cacheReset_i=0 at edge): all valid bits cleared, all outputs 0, major-ID counter 0, missPending cleared. Reset wins over every other input.
- Write port: cacheUpdate_i has priority over naturalWriteEn_i in the same cycle; the selected write sets valid, tag, PID/TID and data at index. cacheUpdate_i also clears missPending.
- Fetch (fetchEnable_i=1, fetchStall_i=0, missPending=0): lookup reads pre-write array contents (read-before-write on same index). Result registered, 1-cycle latency.
- Hit = valid && tag match. Outputs: outputEnable_o=1, cacheMiss_o=0. Bundle = instructions w..min(w+3,15), left-justified, unused slots zero. bundleLen_o = count-1, bundleAddress_o=fetch address, PID/TID from Pid_i/Tid_i, bundleStartMajId_o=counter; counter += count.
- Miss: outputEnable_o=0, cacheMiss_o=1 for one cycle, missed* = fetch address/counter/PID/TID; missPending set.
- While missPending: fetches ignored, outputEnable_o=0, cacheMiss_o=0.
- fetchEnable_i=0 (no stall): outputEnable_o=0 and cacheMiss_o=0 next cycle; data outputs hold.
- fetchStall_i=1: all outputs and counter hold; no lookup; writes still performed.

Optional Feature:
Macro L1I_PID_MATCH_EN. Defined: hit additionally requires stored PID/TID equal Pid_i/Tid_i; mismatch is a miss. Undefined: PID/TID stored but ignored in hit logic.

Test Plan:
- Reset low one edge -> all outputs 0; fetch of 0x0 next -> cacheMiss_o=1, missedAddress_o=0, missedInstMajorId_o=0.
- Natural-write 10 lines at 0x000..0x240, then fetch 0x000..0x270 step 16 -> every result outputEnable_o=1, cacheMiss_o=0, bundleLen_o=3, bundleStartMajId_o increments by 4, first bundle AAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD.
- Fetch 0x280 -> cacheMiss_o=1 one cycle, missedAddress_o=0x280; subsequent fetches 0x290..0x2B0 produce no outputEnable_o; cacheUpdate_i at 0x280 then refetch -> hit.
- Fetch 0x38 (slot 14) on valid line -> bundleLen_o=1, two instructions, rest zero.
- fetchStall_i=1 with fetchEnable_i=1 -> outputs and major ID unchanged.
- cacheUpdate_i and naturalWriteEn_i same index same cycle -> refill data stored.
